// File: rtl/channel_out_pkg.sv
// rtl/channel_out_pkg.sv - shared types and constants for the NeoPixel output channel
package channel_out_pkg;

   localparam int PIXEL_BITS = 24;
   localparam int RAM_AW     = 8;
   localparam int RAM_DW     = 32;
   localparam int RAM_LANES  = RAM_DW / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      LOAD = 2'd2,
      SEND = 2'd3
   } state_t;

endpackage

// File: rtl/channel_ram.sv
// rtl/channel_ram.sv - 256x32 pixel list RAM, byte-lane write port, synchronous read port
module channel_ram
   import channel_out_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [RAM_AW-1:0]     wr_addr_i,
   input  logic [7:0]            wr_data_i,
   input  logic [RAM_LANES-1:0]  wr_byte_en_i,
   input  logic [RAM_AW-1:0]     rd_addr_i,
   output logic [RAM_DW-1:0]     rd_data_o
);

   // No reset on the array or read register so the tools can map it onto block RAM.
   logic [RAM_DW-1:0] mem [0:(1<<RAM_AW)-1];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int i = 0; i < RAM_LANES; i++) begin
            if (wr_byte_en_i[i]) begin
               mem[wr_addr_i][i*8 +: 8] <= wr_data_i;
            end
         end
      end
   end

   // Read-before-write: a same-address collision returns the old word.
   always_ff @(posedge clk_i) begin
      rd_data_o <= mem[rd_addr_i];
   end

endmodule

// File: rtl/channel_out.sv
// rtl/channel_out.sv - walks the pixel list and serialises 24-bit colours onto one LED pin
module channel_out
   import channel_out_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [7:0]  reg_t0h_time_i,
   input  logic [8:0]  reg_t0s_time_i,
   input  logic [7:0]  reg_t1h_time_i,
   input  logic [8:0]  reg_t1s_time_i,
   input  logic        ram_wr_en_i,
   input  logic        ram_wr_done_i,
   input  logic [7:0]  ram_wr_addr_i,
   input  logic [7:0]  ram_wr_data_i,
   input  logic [3:0]  ram_wr_byte_en_i,
   output logic        bit_code_o
);

   state_t                 state;
   state_t                 state_nxt;
   logic [8:0]             tick;
   logic [4:0]             bit_cnt;
   logic [PIXEL_BITS-1:0]  shift;
   logic [RAM_AW-1:0]      next_addr;
   logic [RAM_AW-1:0]      rd_addr;
   logic [RAM_DW-1:0]      rd_data;
   logic                   cur_bit;
   logic [8:0]             cur_h;
   logic [8:0]             cur_s;
   logic                   bit_end;
   logic                   last_bit;
   logic                   bit_nxt;

   channel_ram u_ram (
      .clk_i        (clk_i),
      .wr_en_i      (ram_wr_en_i),
      .wr_addr_i    (ram_wr_addr_i),
      .wr_data_i    (ram_wr_data_i),
      .wr_byte_en_i (ram_wr_byte_en_i),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data)
   );

   // Timing is taken live from the registers, selected by the bit currently at the MSB.
   assign cur_bit  = shift[PIXEL_BITS-1];
   assign cur_h    = cur_bit ? {1'b0, reg_t1h_time_i} : {1'b0, reg_t0h_time_i};
   assign cur_s    = cur_bit ? reg_t1s_time_i : reg_t0s_time_i;
   assign bit_end  = (tick == cur_s);
   assign last_bit = bit_end && (bit_cnt == 5'd0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ram_wr_done_i) state_nxt = READ;
         READ: state_nxt = LOAD;
         LOAD: state_nxt = SEND;
         SEND: if (last_bit) state_nxt = (next_addr == '0) ? IDLE : READ;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bit_nxt = 1'b0;
      if (state == SEND) begin
         bit_nxt = (tick <= cur_h);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bit_code_o <= 1'b0;
      end else begin
         bit_code_o <= bit_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tick      <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         next_addr <= '0;
         rd_addr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               rd_addr <= '0;
               tick    <= '0;
            end
            LOAD: begin
               shift     <= rd_data[PIXEL_BITS-1:0];
               next_addr <= rd_data[RAM_DW-1:PIXEL_BITS];
               bit_cnt   <= 5'(PIXEL_BITS - 1);
               tick      <= '0;
            end
            SEND: begin
               if (bit_end) begin
                  shift   <= shift << 1;
                  tick    <= '0;
                  bit_cnt <= bit_cnt - 5'd1;
                  if (bit_cnt == 5'd0) begin
                     rd_addr <= next_addr;
                  end
               end else begin
                  tick <= tick + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_channel_out.sv
// tb/tb_channel_out.sv - self-checking bench for channel_out against a waveform reference model
module tb_channel_out;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] t0h = '0;
   logic [8:0] t0s = '0;
   logic [7:0] t1h = '0;
   logic [8:0] t1s = '0;
   logic       wr_en = 1'b0;
   logic       done = 1'b0;
   logic [7:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [3:0] wr_be = '0;
   logic       bit_code;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem_m [256];
   bit          exp_q [$];

   always #5 clk = ~clk;

   channel_out dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .reg_t0h_time_i   (t0h),
      .reg_t0s_time_i   (t0s),
      .reg_t1h_time_i   (t1h),
      .reg_t1s_time_i   (t1s),
      .ram_wr_en_i      (wr_en),
      .ram_wr_done_i    (done),
      .ram_wr_addr_i    (wr_addr),
      .ram_wr_data_i    (wr_data),
      .ram_wr_byte_en_i (wr_be),
      .bit_code_o       (bit_code)
   );

   task automatic check(input string tag, input int idx, input logic exp);
      vectors++;
      assert (bit_code === exp) else begin
         miscompares++;
         $error("FAIL %s[%0d] bit_code obs=%0b exp=%0b", tag, idx, bit_code, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] a, input logic [7:0] d, input logic [3:0] be);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      for (int i = 0; i < 4; i++) if (be[i]) mem_m[a][i*8 +: 8] = d;
      @(negedge clk);
      wr_en = 1'b0; wr_be = '0;
   endtask

   task automatic write_word(input logic [7:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) write_byte(a, w[i*8 +: 8], 4'(1 << i));
   endtask

   // Expected pin level for every clock after the start pulse: two low clocks while
   // each word is fetched, then per colour bit (period+1) clocks, high while count <= high time.
   task automatic build_expected();
      int addr;
      int npix;
      logic [31:0] w;
      exp_q = {};
      addr = 0;
      npix = 0;
      do begin
         w = mem_m[addr];
         exp_q.push_back(1'b0);
         exp_q.push_back(1'b0);
         for (int b = 23; b >= 0; b--) begin
            int h;
            int s;
            h = w[b] ? int'(t1h) : int'(t0h);
            s = w[b] ? int'(t1s) : int'(t0s);
            for (int k = 0; k <= s; k++) exp_q.push_back(k <= h);
         end
         addr = int'(w[31:24]);
         npix++;
      end while (addr != 0 && npix < 16);
   endtask

   task automatic run_frame(input string tag, input bit busy);
      int len;
      build_expected();
      len = exp_q.size();
      @(negedge clk); done = 1'b1;
      @(negedge clk); done = 1'b0;
      for (int j = 0; j < len; j++) begin
         @(negedge clk);
         check(tag, j, exp_q[j]);
         done = busy && (j <= len - 2) && (((len - 2 - j) % 2) == 0);
      end
      done = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check({tag, "_tail"}, j, 1'b0);
      end
   endtask

   initial begin
      // Reset held with start pulses: pin stays low, and stays low after release.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         done = ~done;
         check("reset_hold", i, 1'b0);
      end
      done = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset_idle", i, 1'b0);
      end

      // Chain built with split byte-lane writes.
      t0h = 8'd0; t0s = 9'd1; t1h = 8'd1; t1s = 9'd1;
      write_word(8'd9, 32'h00_123456);
      write_byte(8'd0, 8'h01, 4'b1000);
      write_byte(8'd0, 8'h00, 4'b0111);
      write_byte(8'd1, 8'h02, 4'b1000);
      write_byte(8'd1, 8'hAA, 4'b0111);
      write_byte(8'd2, 8'h03, 4'b1000);
      write_byte(8'd2, 8'hCC, 4'b0111);
      write_byte(8'd3, 8'h00, 4'b1000);
      write_byte(8'd3, 8'hFF, 4'b0111);
      run_frame("chain", 1'b0);

      // Start pulses throughout the frame, including its last clock, are ignored.
      run_frame("busy", 1'b1);
      run_frame("after_busy", 1'b0);

      t0h = 8'd3; t0s = 9'd9; t1h = 8'd12; t1s = 9'd9;
      write_word(8'd0, 32'h00_A50F3C);
      run_frame("timing", 1'b0);

      for (int it = 0; it < 4; it++) begin
         logic [7:0] a1;
         logic [7:0] a2;
         a1 = 8'($urandom_range(1, 255));
         do a2 = 8'($urandom_range(1, 255)); while (a2 == a1);
         t0h = 8'($urandom_range(0, 7)); t0s = 9'($urandom_range(0, 7));
         t1h = 8'($urandom_range(0, 7)); t1s = 9'($urandom_range(0, 7));
         write_word(8'd0, {a1, 24'($urandom)});
         write_word(a1, {a2, 24'($urandom)});
         write_word(a2, {8'd0, 24'($urandom)});
         for (int k = 0; k < 3; k++) begin
            write_byte((k % 2 == 0) ? a1 : a2, 8'($urandom), 4'($urandom_range(0, 7)));
         end
         run_frame($sformatf("random%0d", it), 1'b0);
      end

      // Abort mid-frame, then a fresh start from address 0.
      t0h = 8'd2; t0s = 9'd4; t1h = 8'd5; t1s = 9'd5;
      @(negedge clk); done = 1'b1;
      @(negedge clk); done = 1'b0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort", 0, 1'b0);
      @(negedge clk); check("abort_hold", 0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk); check("abort_idle", 0, 1'b0);
      run_frame("restart", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
